// File: rtl/ysyx_23060208_lsu_if.sv
// AXI4 single-beat master/slave bundle used between the LSU and memory.
// One instance carries all five channels; the LSU takes the master view.
interface ysyx_23060208_lsu_if #(
  parameter int XLEN   = 32,
  parameter int AXI_DW = 64,
  parameter int ID_W   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [XLEN-1:0]       awaddr;
  logic [ID_W-1:0]       awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid;
  logic                  wready;
  logic [AXI_DW-1:0]     wdata;
  logic [AXI_DW/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic [ID_W-1:0]       bid;

  logic                  arvalid;
  logic                  arready;
  logic [XLEN-1:0]       araddr;
  logic [ID_W-1:0]       arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [AXI_DW-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_W-1:0]       rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ysyx_23060208_lsu.sv
// Single-outstanding load/store unit: takes one EXU request, issues one AXI4
// beat with lane alignment and ID tagging, returns one registered response.
module ysyx_23060208_lsu #(
  parameter int XLEN    = 32,
  parameter int AXI_DW  = 64,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,

  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic [1:0]            resp_err_o,

  ysyx_23060208_lsu_if.master   m_axi
);

  localparam int STRB_W = AXI_DW / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R_WAIT = 3'd2,
    S_AW_W   = 3'd3,
    S_B_WAIT = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  state_e               state_q;
  logic [ID_W-1:0]      txn_id_q;
  logic [ID_W-1:0]      id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [XLEN-1:0]      addr_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [AXI_DW-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic                 arvalid_q;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 aw_done_q;
  logic                 w_done_q;
  logic                 resp_valid_q;
  logic [XLEN-1:0]      resp_rdata_q;
  logic [1:0]           resp_err_q;

  logic                 misaligned_s;
  logic                 ar_hs_s;
  logic                 aw_hs_s;
  logic                 w_hs_s;
  logic                 r_match_s;
  logic                 b_match_s;
  logic                 timeout_hit_s;
  logic [CNT_W:0]       cnt_inc_s;
  logic                 unused_s;

  // Byte-enable mask for the access size, moved onto its lanes.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] mask;
    case (size)
      2'd0:    mask = STRB_W'(4'h1);
      2'd1:    mask = STRB_W'(4'h3);
      default: mask = STRB_W'(4'hF);
    endcase
    return mask << off;
  endfunction

  // Pull the addressed lanes down to bit 0 and sign/zero-extend by size.
  function automatic logic [XLEN-1:0] extend_load(input logic [AXI_DW-1:0] beat,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [1:0]        size,
                                                  input logic              uns);
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] ext;
    low = XLEN'(beat >> {off, 3'b000});
    case (size)
      2'd0:    ext = uns ? {{(XLEN-8){1'b0}}, low[7:0]}
                         : {{(XLEN-8){low[7]}}, low[7:0]};
      2'd1:    ext = uns ? {{(XLEN-16){1'b0}}, low[15:0]}
                         : {{(XLEN-16){low[15]}}, low[15:0]};
      default: ext = low;
    endcase
    return ext;
  endfunction

  // Request alignment check against the natural boundary of its size.
  always_comb begin
    misaligned_s = 1'b0;
    case (req_size_i)
      2'd0:    misaligned_s = 1'b0;
      2'd1:    misaligned_s = req_addr_i[0];
      default: misaligned_s = |req_addr_i[1:0];
    endcase
  end

  // Channel handshakes, ID matching and the timeout comparison.
  always_comb begin
    ar_hs_s       = arvalid_q & m_axi.arready;
    aw_hs_s       = awvalid_q & m_axi.awready;
    w_hs_s        = wvalid_q  & m_axi.wready;
    r_match_s     = m_axi.rvalid & (m_axi.rid == id_q);
    b_match_s     = m_axi.bvalid & (m_axi.bid == id_q);
    cnt_inc_s     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    timeout_hit_s = (TIMEOUT != 0) && (cnt_inc_s == (CNT_W+1)'(TIMEOUT));
  end

  // Main FSM: state, transaction bookkeeping and every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      txn_id_q     <= {ID_W{1'b0}};
      id_q         <= {ID_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      addr_q       <= {XLEN{1'b0}};
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= {AXI_DW{1'b0}};
      wstrb_q      <= {STRB_W{1'b0}};
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {XLEN{1'b0}};
      resp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= AXI_DW'(req_wdata_i) << {req_addr_i[OFF_W-1:0], 3'b000};
            wstrb_q <= lane_strb(req_size_i, req_addr_i[OFF_W-1:0]);
            if (misaligned_s) begin
              // Misaligned accesses never reach the bus and burn no ID.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= {XLEN{1'b0}};
              resp_err_q   <= ERR_ALIGN;
            end else begin
              id_q     <= txn_id_q;
              txn_id_q <= txn_id_q + ID_W'(1);
              if (req_we_i) begin
                state_q   <= S_AW_W;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
              end else begin
                state_q   <= S_AR;
                arvalid_q <= 1'b1;
              end
            end
          end
        end

        S_AR: begin
          if (ar_hs_s) begin
            arvalid_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            state_q   <= S_R_WAIT;
          end
        end

        S_R_WAIT: begin
          if (r_match_s) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= m_axi.rresp[1] ? ERR_BUS : ERR_OK;
            resp_rdata_q <= m_axi.rresp[1] ? {XLEN{1'b0}}
                          : extend_load(m_axi.rdata, addr_q[OFF_W-1:0], size_q, uns_q);
          end else if (timeout_hit_s) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_TMO;
            resp_rdata_q <= {XLEN{1'b0}};
          end else begin
            cnt_q <= cnt_inc_s[CNT_W-1:0];
          end
        end

        S_AW_W: begin
          // AW and W complete independently; either may finish first.
          if (aw_hs_s) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_B_WAIT;
          end
        end

        S_B_WAIT: begin
          if (b_match_s) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= m_axi.bresp[1] ? ERR_BUS : ERR_OK;
            resp_rdata_q <= {XLEN{1'b0}};
          end else if (timeout_hit_s) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_TMO;
            resp_rdata_q <= {XLEN{1'b0}};
          end else begin
            cnt_q <= cnt_inc_s[CNT_W-1:0];
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awid    = id_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = {1'b0, size_q};
  assign m_axi.awburst = 2'b01;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = wvalid_q;

  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arid    = id_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = {1'b0, size_q};
  assign m_axi.arburst = 2'b01;

  // Idle drains stale beats; the wait states accept the one being tracked.
  assign m_axi.rready = (state_q == S_IDLE) || (state_q == S_R_WAIT);
  assign m_axi.bready = (state_q == S_IDLE) || (state_q == S_B_WAIT);

  assign unused_s = ^{m_axi.rlast, m_axi.rresp[0], m_axi.bresp[0]};

endmodule
